sr_latch_driver: RTL and testbench

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_pkg.sv | 17 +
 rtl/sr_debounce.sv | 43 ++++
 rtl/sr_latch_driver.sv | 133 +++++++++++++
 tb/tb_sr_latch_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch pulse driver: FSM state encoding and default timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        RST_PULSE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_PULSE_CYCLES    = 4;
    localparam int DEF_GAP_CYCLES      = 2;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer followed by a stable-sample debouncer for one raw button.
// Latency: 2+DEBOUNCE_CYCLES clocks from a stable raw change to a change on db_lvl.
// Backpressure: none; the level is always presented.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db_lvl
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // The counter tallies consecutive samples that disagree with db_lvl; any agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            db_lvl <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == db_lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                db_lvl <= sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Turns debounced set/reset buttons into non-overlapping active-low pulses for a NAND SR latch.
// Latency: first pulse starts 3+DEBOUNCE_CYCLES clocks after a stable raw rising edge.
// Backpressure: requests while busy are held in one-deep pending flags; repeats of a pending kind are dropped.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic q_exp
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    logic       set_lvl, rst_lvl;
    logic       set_lvl_q, rst_lvl_q;
    logic       set_req, rst_req;
    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       pending_s, pending_r, pend_s_nxt, pend_r_nxt;
    logic       q_exp_nxt;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_set),
        .db_lvl (set_lvl)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_reset),
        .db_lvl (rst_lvl)
    );

    assign set_req = set_lvl & ~set_lvl_q;
    assign rst_req = rst_lvl & ~rst_lvl_q;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        q_exp_nxt  = q_exp;
        pend_s_nxt = pending_s;
        pend_r_nxt = pending_r;

        if (state != IDLE) begin
            if (set_req) pend_s_nxt = 1'b1;
            if (rst_req) pend_r_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // Reset has priority; a simultaneous set is parked so it runs afterwards.
                if (rst_req || pending_r) begin
                    state_nxt  = RST_PULSE;
                    pend_r_nxt = 1'b0;
                    if (set_req) pend_s_nxt = 1'b1;
                end else if (set_req || pending_s) begin
                    state_nxt  = SET_PULSE;
                    pend_s_nxt = 1'b0;
                end
            end
            SET_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    q_exp_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            RST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    q_exp_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pulse outputs are decoded from the next state so they are flops aligned with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pending_s <= 1'b0;
            pending_r <= 1'b0;
            q_exp     <= 1'b0;
            s_n       <= 1'b1;
            r_n       <= 1'b1;
            set_lvl_q <= 1'b0;
            rst_lvl_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pending_s <= pend_s_nxt;
            pending_r <= pend_r_nxt;
            q_exp     <= q_exp_nxt;
            s_n       <= (state_nxt != SET_PULSE);
            r_n       <= (state_nxt != RST_PULSE);
            set_lvl_q <= set_lvl;
            rst_lvl_q <= rst_lvl;
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver at default parameters (debounce 16, pulse 4, gap 2).
module tb_sr_latch_driver;

    logic clk;
    logic rst_n;
    logic btn_set;
    logic btn_reset;
    logic s_n;
    logic r_n;
    logic busy;
    logic q_exp;

    int n_checks = 0;
    int n_pass   = 0;
    int s_fall   = 0;
    int r_fall   = 0;
    int s_len    = 0;
    int r_len    = 0;
    logic busy_seen = 1'b0;

    sr_latch_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_set   (btn_set),
        .btn_reset (btn_reset),
        .s_n       (s_n),
        .r_n       (r_n),
        .busy      (busy),
        .q_exp     (q_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Protocol monitor: never both low, every completed low run is exactly 4 clocks.
    always @(negedge clk) begin
        if (!rst_n) begin
            s_len = 0;
            r_len = 0;
        end else begin
            check("never_both_low", {31'd0, (s_n | r_n)}, 32'd1);
            if (!s_n) begin
                if (s_len == 0) s_fall++;
                s_len++;
            end else if (s_len != 0) begin
                check("s_n_run_len", s_len, 32'd4);
                s_len = 0;
            end
            if (!r_n) begin
                if (r_len == 0) r_fall++;
                r_len++;
            end else if (r_len != 0) begin
                check("r_n_run_len", r_len, 32'd4);
                r_len = 0;
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    initial begin
        rst_n     = 1'b0;
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        tick(3);
        check("rst_s_n", s_n, 1);
        check("rst_r_n", r_n, 1);
        check("rst_busy", busy, 0);
        check("rst_q_exp", q_exp, 0);
        rst_n = 1'b1;
        tick(2);

        // Single held set press: pulse starts 19 clocks after the rise.
        btn_set = 1'b1;
        tick(18);
        check("t1_pre_s_n", s_n, 1);
        check("t1_pre_busy", busy, 0);
        check("t1_pre_q", q_exp, 0);
        tick(1);
        check("t1_start_s_n", s_n, 0);
        check("t1_start_r_n", r_n, 1);
        check("t1_start_busy", busy, 1);
        tick(3);
        check("t1_last_s_n", s_n, 0);
        tick(1);
        check("t1_end_s_n", s_n, 1);
        check("t1_end_q", q_exp, 1);
        check("t1_gap_busy", busy, 1);
        tick(2);
        check("t1_idle_busy", busy, 0);
        tick(15);
        btn_set = 1'b0;
        tick(30);
        check("t1_s_count", s_fall, 1);
        check("t1_r_count", r_fall, 0);

        // Short glitch is filtered out.
        busy_seen = 1'b0;
        btn_set   = 1'b1;
        tick(10);
        btn_set = 1'b0;
        tick(30);
        check("t2_busy_seen", {31'd0, busy_seen}, 0);
        check("t2_s_count", s_fall, 1);

        // Simultaneous set and reset: reset first, then set.
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        tick(19);
        check("t3_r_start", r_n, 0);
        check("t3_s_idle", s_n, 1);
        check("t3_busy", busy, 1);
        tick(4);
        check("t3_r_end", r_n, 1);
        check("t3_q_after_r", q_exp, 0);
        tick(3);
        check("t3_s_start", s_n, 0);
        check("t3_r_idle", r_n, 1);
        tick(6);
        check("t3_q_final", q_exp, 1);
        check("t3_busy_final", busy, 0);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        tick(30);
        check("t3_s_count", s_fall, 2);
        check("t3_r_count", r_fall, 1);

        // Reset request lands during a set pulse and is queued.
        btn_set = 1'b1;
        tick(2);
        btn_reset = 1'b1;
        tick(17);
        check("t4_s_start", s_n, 0);
        tick(4);
        check("t4_s_end", s_n, 1);
        check("t4_gap_r_n", r_n, 1);
        check("t4_q_set", q_exp, 1);
        tick(3);
        check("t4_r_start", r_n, 0);
        tick(4);
        check("t4_r_end", r_n, 1);
        check("t4_q_reset", q_exp, 0);
        tick(2);
        check("t4_busy_final", busy, 0);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        tick(30);
        check("t4_s_count", s_fall, 3);
        check("t4_r_count", r_fall, 2);

        // Reset asserted in the second cycle of a set pulse aborts it.
        btn_set = 1'b1;
        tick(20);
        check("t5_mid_s_n", s_n, 0);
        rst_n = 1'b0;
        #1;
        check("t5_abort_s_n", s_n, 1);
        check("t5_abort_r_n", r_n, 1);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_q", q_exp, 0);
        btn_set = 1'b0;
        tick(3);
        rst_n     = 1'b1;
        busy_seen = 1'b0;
        tick(40);
        check("t5_s_count", s_fall, 4);
        check("t5_r_count", r_fall, 2);
        check("t5_q_final", q_exp, 0);
        check("t5_busy_seen", {31'd0, busy_seen}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
